// File: rtl/regbank_wr_arbiter.sv
// Write-port owner for the 32-entry register bank.
// Zeroes every register after reset, then shares the single write port
// among NREQ writeback requesters with round-robin valid/ready arbitration.
// The bank-side outputs are registered so they can feed the bank directly.
module regbank_wr_arbiter #(
    parameter int NREQ     = 2,
    parameter bit CLEAR_EN = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 write,
    output logic [4:0]           wrAddr,
    output logic [31:0]          wrData,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q,  state_d;
    logic [4:0]      clrCnt_q, clrCnt_d;
    logic [PW-1:0]   rrPtr_q,  rrPtr_d;
    logic            write_q,  write_d;
    logic [4:0]      wrAddr_q, wrAddr_d;
    logic [31:0]     wrData_q, wrData_d;

    logic            grantValid;
    logic [PW-1:0]   grantIdx;
    logic [PW:0]     scanSum;
    logic [PW-1:0]   scanIdx;
    logic [4:0]      selAddr;
    logic [31:0]     selData;
    logic            runNow;

    assign runNow = (state_q == ST_RUN);

    // Round-robin scan: first valid requester starting at rrPtr_q, wrapping mod NREQ.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        scanSum    = '0;
        scanIdx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scanSum = {1'b0, rrPtr_q} + (PW+1)'(k);
            if (scanSum >= (PW+1)'(NREQ)) begin
                scanSum = scanSum - (PW+1)'(NREQ);
            end
            scanIdx = scanSum[PW-1:0];
            if (!grantValid && req_valid[scanIdx]) begin
                grantValid = 1'b1;
                grantIdx   = scanIdx;
            end
        end
    end

    // Pick the granted requester's address and data out of the flattened buses.
    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantIdx == PW'(i)) begin
                selAddr = req_addr[5*i +: 5];
                selData = req_data[32*i +: 32];
            end
        end
    end

    // One-hot ready only in RUN; held low while reset is asserted so a
    // requester never sees a handshake that reset is about to swallow.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = runNow && !rst && grantValid && (grantIdx == PW'(i));
        end
    end

    // Next-state logic: clear sweep in CLEAR, arbitrated writeback in RUN.
    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        rrPtr_d  = rrPtr_q;
        write_d  = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        unique case (state_q)
            ST_CLEAR: begin
                write_d  = 1'b1;
                wrAddr_d = clrCnt_q;
                wrData_d = '0;
                clrCnt_d = clrCnt_q + 5'd1;
                if (clrCnt_q == 5'd31) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (grantValid) begin
                    write_d  = !(ZERO_REG && (selAddr == 5'd0));
                    wrAddr_d = selAddr;
                    wrData_d = selData;
                    if (grantIdx == PW'(NREQ-1)) begin
                        rrPtr_d = '0;
                    end else begin
                        rrPtr_d = grantIdx + PW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers; reset wins over any clear step or transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR_EN ? ST_CLEAR : ST_RUN;
            clrCnt_q <= '0;
            rrPtr_q  <= '0;
            write_q  <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
            rrPtr_q  <= rrPtr_d;
            write_q  <= write_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
        end
    end

    assign write  = write_q;
    assign wrAddr = wrAddr_q;
    assign wrData = wrData_q;
    assign busy   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: a randomized run of a 3-requester instance
// against an abstract model (clear index, round-robin pointer, pending
// requests, register bank image), plus a short directed run of a
// 2-requester instance with the clear sweep and zero-register guard disabled.
module tb_regbank_wr_arbiter;

    localparam int NREQ = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic                rst;
    logic [NREQ-1:0]     reqValid;
    logic [5*NREQ-1:0]   reqAddr;
    logic [32*NREQ-1:0]  reqData;
    logic [NREQ-1:0]     reqReady;
    logic                write;
    logic [4:0]          wrAddr;
    logic [31:0]         wrData;
    logic                busy;

    // Second instance signals (NREQ=2, CLEAR_EN=0, ZERO_REG=0)
    logic                rstB;
    logic [1:0]          validB;
    logic [9:0]          addrB;
    logic [63:0]         dataB;
    logic [1:0]          readyB;
    logic                writeB;
    logic [4:0]          wrAddrB;
    logic [31:0]         wrDataB;
    logic                busyB;

    regbank_wr_arbiter #(.NREQ(NREQ), .CLEAR_EN(1'b1), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_addr(reqAddr),
        .req_data(reqData), .req_ready(reqReady), .write(write),
        .wrAddr(wrAddr), .wrData(wrData), .busy(busy)
    );

    regbank_wr_arbiter #(.NREQ(2), .CLEAR_EN(1'b0), .ZERO_REG(1'b0)) dutB (
        .clk(clk), .rst(rstB), .req_valid(validB), .req_addr(addrB),
        .req_data(dataB), .req_ready(readyB), .write(writeB),
        .wrAddr(wrAddrB), .wrData(wrDataB), .busy(busyB)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state
    int          mClrIdx;
    int          mPtr;
    logic        mWrite;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    bit          pend  [NREQ];
    logic [4:0]  pAddr [NREQ];
    logic [31:0] pData [NREQ];
    int          grantCount [NREQ];
    logic [31:0] modelBank [32] = '{default: 32'hA5A5A5A5};
    logic [31:0] portBank  [32] = '{default: 32'hA5A5A5A5};

    // Register bank behind the main instance's write port
    always @(posedge clk) begin
        if (write === 1'b1) portBank[wrAddr] <= wrData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    // One cycle of the main instance: check registered outputs, drive new
    // inputs, check the grant, then advance the model across the next edge.
    task automatic applyStimulus(input logic r, input int genPct);
        int g;
        logic [NREQ-1:0] expReady;
        @(negedge clk);
        checkOutput("write",  32'(write),  32'(mWrite));
        checkOutput("wrAddr", 32'(wrAddr), 32'(mAddr));
        checkOutput("wrData", wrData, mData);
        checkOutput("busy",   32'(busy),   32'(mClrIdx < 32));
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < genPct) begin
                pend[i]  = 1'b1;
                pAddr[i] = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                pData[i] = $urandom;
            end
        end
        rst = r;
        for (int i = 0; i < NREQ; i++) begin
            reqValid[i]       = pend[i];
            reqAddr[5*i +: 5] = pend[i] ? pAddr[i] : 5'($urandom_range(31));
            reqData[32*i +: 32] = pend[i] ? pData[i] : $urandom;
        end
        #1;
        g = -1;
        if (!r && mClrIdx >= 32) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && pend[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
            end
        end
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("req_ready", 32'(reqReady), 32'(expReady));
        if (r) begin
            mWrite = 1'b0; mAddr = '0; mData = '0; mClrIdx = 0; mPtr = 0;
        end else if (mClrIdx < 32) begin
            mWrite = 1'b1; mAddr = 5'(mClrIdx); mData = '0;
            modelBank[mClrIdx] = '0;
            mClrIdx++;
        end else if (g >= 0) begin
            mWrite = (pAddr[g] != 5'd0);
            mAddr  = pAddr[g];
            mData  = pData[g];
            if (mWrite) modelBank[mAddr] = mData;
            mPtr = (g + 1) % NREQ;
            pend[g] = 1'b0;
            grantCount[g]++;
        end else begin
            mWrite = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; reqValid = '0; reqAddr = '0; reqData = '0;
        rstB = 1'b1; validB = '0; addrB = '0; dataB = '0;
        mClrIdx = 0; mPtr = 0; mWrite = 1'b0; mAddr = '0; mData = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; pAddr[i] = '0; pData[i] = '0; grantCount[i] = 0;
        end

        // Plain clear sweep with no traffic, then a few idle RUN cycles
        applyStimulus(1'b1, 0);
        for (int c = 0; c < 36; c++) applyStimulus(1'b0, 0);

        // Reset part-way into the clear, then again with requests pending
        applyStimulus(1'b1, 0);
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, 40);
        applyStimulus(1'b1, 0);
        for (int c = 0; c < 20; c++) applyStimulus(1'b0, 60);
        applyStimulus(1'b1, 100);

        // All requesters continuously valid: strict rotation after the clear
        for (int c = 0; c < 32; c++) applyStimulus(1'b0, 100);
        for (int i = 0; i < NREQ; i++) grantCount[i] = 0;
        for (int c = 0; c < 30; c++) applyStimulus(1'b0, 100);
        for (int i = 0; i < NREQ; i++)
            checkOutput($sformatf("rr_share[%0d]", i), 32'(grantCount[i]), 32'd10);

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++)
            applyStimulus(($urandom_range(119) == 0) ? 1'b1 : 1'b0, 45);

        // Drain and compare the bank image
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 0);
        for (int a = 0; a < 32; a++)
            checkOutput($sformatf("bank[%0d]", a), portBank[a], modelBank[a]);

        // Second instance: no clear, address 0 writable, first-cycle acceptance
        @(negedge clk);
        rstB = 1'b0;
        validB = 2'b11;
        addrB = {5'd7, 5'd0};
        dataB = {32'hAAAA5555, 32'h00001234};
        #1;
        checkOutput("B.busy_rst",  32'(busyB),  32'd0);
        checkOutput("B.write_rst", 32'(writeB), 32'd0);
        checkOutput("B.addr_rst",  32'(wrAddrB), 32'd0);
        checkOutput("B.ready0",    32'(readyB), 32'd1);
        @(posedge clk); #1;
        checkOutput("B.write0", 32'(writeB), 32'd1);
        checkOutput("B.addr0",  32'(wrAddrB), 32'd0);
        checkOutput("B.data0",  wrDataB, 32'h00001234);
        validB = 2'b10;
        #1;
        checkOutput("B.ready1", 32'(readyB), 32'd2);
        @(posedge clk); #1;
        checkOutput("B.write1", 32'(writeB), 32'd1);
        checkOutput("B.addr1",  32'(wrAddrB), 32'd7);
        checkOutput("B.data1",  wrDataB, 32'hAAAA5555);
        validB = 2'b01;
        addrB = {5'd9, 5'd3};
        dataB = {32'hFFFF0000, 32'h00000055};
        #1;
        checkOutput("B.ready2", 32'(readyB), 32'd1);
        @(posedge clk); #1;
        checkOutput("B.addr2", 32'(wrAddrB), 32'd3);
        addrB = {5'd9, 5'd4};
        dataB = {32'hFFFF0000, 32'h00000066};
        #1;
        checkOutput("B.ready3", 32'(readyB), 32'd1);
        @(posedge clk); #1;
        checkOutput("B.write3", 32'(writeB), 32'd1);
        checkOutput("B.addr3",  32'(wrAddrB), 32'd4);
        checkOutput("B.data3",  wrDataB, 32'h00000066);
        validB = 2'b00;
        #1;
        checkOutput("B.ready_idle", 32'(readyB), 32'd0);
        @(posedge clk); #1;
        checkOutput("B.write_idle", 32'(writeB), 32'd0);
        checkOutput("B.addr_hold",  32'(wrAddrB), 32'd4);
        checkOutput("B.data_hold",  wrDataB, 32'h00000066);
        checkOutput("B.busy_run",   32'(busyB), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
